julia_frame_scheduler: RTL

// Frame-level controller for a pool of NUM_CORES Julia iteration cores. Walks a

---
 rtl/julia_frame_scheduler_if.sv | 53 +++++
 rtl/julia_frame_scheduler.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/julia_frame_scheduler_if.sv
// ----------------------------------------------------------------------------
// julia_frame_scheduler_if : config, core-pool and result-stream bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface julia_frame_scheduler_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_ITER_WIDTH = 16,
  parameter int NUM_CORES      = 4,
  parameter int X_W            = 10,
  parameter int Y_W            = 9
);
  logic                                frame_start_i;
  logic [DATA_WIDTH-1:0]               origin_x_i;
  logic [DATA_WIDTH-1:0]               origin_y_i;
  logic [DATA_WIDTH-1:0]               step_x_i;
  logic [DATA_WIDTH-1:0]               step_y_i;
  logic [DATA_WIDTH-1:0]               cx_i;
  logic [DATA_WIDTH-1:0]               cy_i;
  logic [MAX_ITER_WIDTH-1:0]           max_iter_i;
  logic                                busy_o;
  logic                                frame_done_o;
  logic [NUM_CORES-1:0]                core_start_o;
  logic [DATA_WIDTH-1:0]               core_zx_o;
  logic [DATA_WIDTH-1:0]               core_zy_o;
  logic [DATA_WIDTH-1:0]               core_cx_o;
  logic [DATA_WIDTH-1:0]               core_cy_o;
  logic [MAX_ITER_WIDTH-1:0]           core_max_iter_o;
  logic [NUM_CORES-1:0]                core_done_i;
  logic [NUM_CORES*MAX_ITER_WIDTH-1:0] core_iter_i;
  logic                                res_valid_o;
  logic                                res_ready_i;
  logic [X_W-1:0]                      res_x_o;
  logic [Y_W-1:0]                      res_y_o;
  logic [MAX_ITER_WIDTH-1:0]           res_iter_o;

  modport master (
    input  frame_start_i, origin_x_i, origin_y_i, step_x_i, step_y_i, cx_i, cy_i,
           max_iter_i, core_done_i, core_iter_i, res_ready_i,
    output busy_o, frame_done_o, core_start_o, core_zx_o, core_zy_o, core_cx_o,
           core_cy_o, core_max_iter_o, res_valid_o, res_x_o, res_y_o, res_iter_o
  );

  modport slave (
    output frame_start_i, origin_x_i, origin_y_i, step_x_i, step_y_i, cx_i, cy_i,
           max_iter_i, core_done_i, core_iter_i, res_ready_i,
    input  busy_o, frame_done_o, core_start_o, core_zx_o, core_zy_o, core_cx_o,
           core_cy_o, core_max_iter_o, res_valid_o, res_x_o, res_y_o, res_iter_o
  );
endinterface

`default_nettype wire

// File: rtl/julia_frame_scheduler.sv
// ----------------------------------------------------------------------------
// julia_frame_scheduler : raster pixel dispatch to a Julia core pool, RR result collect
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module julia_frame_scheduler #(
  parameter int INTEGER_BITS    = 8,
  parameter int FRACTIONAL_BITS = 24,
  parameter int MAX_ITER_WIDTH  = 16,
  parameter int NUM_CORES       = 4,
  parameter int FRAME_W         = 640,
  parameter int FRAME_H         = 480
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  julia_frame_scheduler_if.master bus
);
  localparam int DATA_WIDTH = INTEGER_BITS + FRACTIONAL_BITS;
  localparam int X_W        = $clog2(FRAME_W);
  localparam int Y_W        = $clog2(FRAME_H);
  localparam int IDX_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] origin_x;
  logic [DATA_WIDTH-1:0] step_x;
  logic [DATA_WIDTH-1:0] step_y;
  logic [DATA_WIDTH-1:0] zx;
  logic [DATA_WIDTH-1:0] zy;
  logic [X_W-1:0]        px;
  logic [Y_W-1:0]        py;
  logic [NUM_CORES-1:0]  slot_busy;
  logic [X_W-1:0]        tag_x [NUM_CORES];
  logic [Y_W-1:0]        tag_y [NUM_CORES];
  logic [IDX_W-1:0]      rr_ptr;

  logic                  any_free;
  logic [IDX_W-1:0]      free_idx;
  logic [NUM_CORES-1:0]  eligible;
  logic                  grant_found;
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W-1:0]      cand_idx;
  int                    cand;
  logic                  dispatch;
  logic                  grant;
  logic [NUM_CORES-1:0]  start_oh;
  logic [NUM_CORES-1:0]  grant_oh;

  // A slot in its start cycle still sees the previous job's stale done level.
  assign eligible = slot_busy & bus.core_done_i & ~bus.core_start_o;

  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (!slot_busy[k]) begin
        any_free = 1'b1;
        free_idx = IDX_W'(k);
      end
    end
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_CORES) cand = cand - NUM_CORES;
      cand_idx = IDX_W'(cand);
      if (!grant_found && eligible[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign dispatch = (state == DISPATCH) && any_free;
  assign grant    = ((state == DISPATCH) || (state == DRAIN)) && grant_found &&
                    (!bus.res_valid_o || bus.res_ready_i);
  assign start_oh = dispatch ? (NUM_CORES'(1) << free_idx) : '0;
  assign grant_oh = grant ? (NUM_CORES'(1) << grant_idx) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state               <= IDLE;
      bus.busy_o          <= 1'b0;
      bus.frame_done_o    <= 1'b0;
      bus.core_start_o    <= '0;
      bus.core_zx_o       <= '0;
      bus.core_zy_o       <= '0;
      bus.core_cx_o       <= '0;
      bus.core_cy_o       <= '0;
      bus.core_max_iter_o <= '0;
      bus.res_valid_o     <= 1'b0;
      bus.res_x_o         <= '0;
      bus.res_y_o         <= '0;
      bus.res_iter_o      <= '0;
      origin_x            <= '0;
      step_x              <= '0;
      step_y              <= '0;
      zx                  <= '0;
      zy                  <= '0;
      px                  <= '0;
      py                  <= '0;
      slot_busy           <= '0;
      rr_ptr              <= '0;
      for (int k = 0; k < NUM_CORES; k++) begin
        tag_x[k] <= '0;
        tag_y[k] <= '0;
      end
    end else begin
      bus.core_start_o <= '0;
      bus.frame_done_o <= 1'b0;
      slot_busy        <= (slot_busy & ~grant_oh) | start_oh;

      if (grant) begin
        bus.res_valid_o <= 1'b1;
        bus.res_x_o     <= tag_x[grant_idx];
        bus.res_y_o     <= tag_y[grant_idx];
        bus.res_iter_o  <= bus.core_iter_i[grant_idx*MAX_ITER_WIDTH +: MAX_ITER_WIDTH];
        rr_ptr          <= (grant_idx == IDX_W'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
      end else if (bus.res_ready_i) begin
        bus.res_valid_o <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.frame_start_i) begin
            origin_x            <= bus.origin_x_i;
            step_x              <= bus.step_x_i;
            step_y              <= bus.step_y_i;
            bus.core_cx_o       <= bus.cx_i;
            bus.core_cy_o       <= bus.cy_i;
            bus.core_max_iter_o <= bus.max_iter_i;
            zx                  <= bus.origin_x_i;
            zy                  <= bus.origin_y_i;
            px                  <= '0;
            py                  <= '0;
            bus.busy_o          <= 1'b1;
            state               <= DISPATCH;
          end
        end
        DISPATCH: begin
          if (any_free) begin
            bus.core_start_o[free_idx] <= 1'b1;
            bus.core_zx_o              <= zx;
            bus.core_zy_o              <= zy;
            tag_x[free_idx]            <= px;
            tag_y[free_idx]            <= py;
            if (px == X_W'(FRAME_W - 1)) begin
              px <= '0;
              zx <= origin_x;
              py <= py + 1'b1;
              zy <= zy + step_y;
              if (py == Y_W'(FRAME_H - 1)) state <= DRAIN;
            end else begin
              px <= px + 1'b1;
              zx <= zx + step_x;
            end
          end
        end
        DRAIN: begin
          if ((slot_busy == '0) && !bus.res_valid_o) begin
            bus.frame_done_o <= 1'b1;
            state            <= DONE;
          end
        end
        default: begin
          bus.busy_o <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end
endmodule

`default_nettype wire
